// File: rtl/dtc_vote_pkg.sv
// Shared types and helpers for the decision-tree window vote stage.
package dtc_vote_pkg;

    typedef enum logic [1:0] {ACC, EVAL, HOLD} vote_state_e;

    localparam int OUT_W_DEF = 10;
    // Wide enough for any legal window (WIN <= 255) plus the doubling compare.
    localparam int VOTE_W = 9;

    function automatic logic majority(input logic [VOTE_W-1:0] cnt,
                                      input logic [VOTE_W-1:0] n);
        return {cnt, 1'b0} > {1'b0, n};
    endfunction

endpackage

// File: rtl/dtc_vote_bitcnt.sv
// One per-bit set counter with its majority decision against the sample count.
// DTC_VOTE_COUNTS_EN exposes the raw count for the top's count output.
module dtc_vote_bitcnt
    import dtc_vote_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc_en,
    input  logic             in_bit,
    input  logic [CNT_W-1:0] n,
`ifdef DTC_VOTE_COUNTS_EN
    output logic [CNT_W-1:0] cnt,
`endif
    output logic             maj
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc_en && in_bit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign maj = majority(VOTE_W'(cnt_q), VOTE_W'(n));

`ifdef DTC_VOTE_COUNTS_EN
    assign cnt = cnt_q;
`endif

endmodule

// File: rtl/dtc_window_vote.sv
// Window majority vote over decision-tree outputs; one voted word per window.
// DTC_VOTE_COUNTS_EN adds out_counts, the registered per-bit counts of the window.
//   state | meaning
//   ACC   | accepting samples, counting set bits
//   EVAL  | one cycle to register the majority word and sample count
//   HOLD  | presenting result until the sink takes it
module dtc_window_vote
    import dtc_vote_pkg::*;
#(
    parameter  int OUT_W = OUT_W_DEF,
    parameter  int WIN   = 8,
    localparam int CNT_W = $clog2(WIN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OUT_W-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
`ifdef DTC_VOTE_COUNTS_EN
    output logic [OUT_W*CNT_W-1:0] out_counts,
`endif
    output logic [CNT_W-1:0]   out_n
);

    vote_state_e      state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_n_q, out_n_d;
    logic [OUT_W-1:0] maj_w;
    logic             clr;
    logic             inc_en;
    logic             accept;
    logic             win_full;

`ifdef DTC_VOTE_COUNTS_EN
    logic [OUT_W*CNT_W-1:0] cnt_w;
    logic [OUT_W*CNT_W-1:0] counts_q, counts_d;
`endif

    for (genvar i = 0; i < OUT_W; i++) begin : g_bit
        dtc_vote_bitcnt #(.CNT_W(CNT_W)) u_bitcnt (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .inc_en (inc_en),
            .in_bit (in_data[i]),
            .n      (n_q),
`ifdef DTC_VOTE_COUNTS_EN
            .cnt    (cnt_w[i*CNT_W +: CNT_W]),
`endif
            .maj    (maj_w[i])
        );
    end

    // Gated by rst so the stage never looks ready before the state is known.
    assign in_ready = (state_q == ACC) && !rst;
    assign accept   = in_valid && in_ready;
    assign win_full = ({1'b0, n_q} + (CNT_W+1)'(1)) == (CNT_W+1)'(WIN);

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        out_data_d = out_data_q;
        out_n_d    = out_n_q;
        clr        = 1'b0;
        inc_en     = 1'b0;
`ifdef DTC_VOTE_COUNTS_EN
        counts_d   = counts_q;
`endif
        case (state_q)
            ACC: begin
                if (accept) begin
                    inc_en = 1'b1;
                    n_d    = n_q + CNT_W'(1);
                    if (win_full || in_last) begin
                        state_d = EVAL;
                    end
                end
            end
            EVAL: begin
                out_data_d = maj_w;
                out_n_d    = n_q;
`ifdef DTC_VOTE_COUNTS_EN
                counts_d   = cnt_w;
`endif
                state_d    = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    clr     = 1'b1;
                    n_d     = '0;
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACC;
            n_q        <= '0;
            out_data_q <= '0;
            out_n_q    <= '0;
`ifdef DTC_VOTE_COUNTS_EN
            counts_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            out_data_q <= out_data_d;
            out_n_q    <= out_n_d;
`ifdef DTC_VOTE_COUNTS_EN
            counts_q   <= counts_d;
`endif
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_n     = out_n_q;
`ifdef DTC_VOTE_COUNTS_EN
    assign out_counts = counts_q;
`endif

endmodule

// File: tb/tb_dtc_window_vote.sv
// Directed bench for dtc_window_vote: a WIN=8 instance (a) and a WIN=1 instance (b).
module tb_dtc_window_vote;

    localparam int OW  = 10;
    localparam int CWA = $clog2(8 + 1);
    localparam int CWB = $clog2(1 + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           in_valid_a = 1'b0, in_ready_a, in_last_a = 1'b0;
    logic [OW-1:0]  in_data_a = '0, out_data_a;
    logic           out_valid_a, out_ready_a = 1'b0;
    logic [CWA-1:0] out_n_a;

    logic           in_valid_b = 1'b0, in_ready_b, in_last_b = 1'b0;
    logic [OW-1:0]  in_data_b = '0, out_data_b;
    logic           out_valid_b, out_ready_b = 1'b0;
    logic [CWB-1:0] out_n_b;

`ifdef DTC_VOTE_COUNTS_EN
    logic [OW*CWA-1:0] out_counts_a;
    logic [OW*CWB-1:0] out_counts_b;
`endif

    dtc_window_vote #(.OUT_W(OW), .WIN(8)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a), .in_last(in_last_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
`ifdef DTC_VOTE_COUNTS_EN
        .out_counts(out_counts_a),
`endif
        .out_n(out_n_a)
    );

    dtc_window_vote #(.OUT_W(OW), .WIN(1)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_last(in_last_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
`ifdef DTC_VOTE_COUNTS_EN
        .out_counts(out_counts_b),
`endif
        .out_n(out_n_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Entered and left on a negedge; the sample is taken at the intervening posedge.
    task automatic push_a(input logic [OW-1:0] d, input logic l);
        int g = 0;
        in_valid_a = 1'b1; in_data_a = d; in_last_a = l;
        while (!in_ready_a && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) check("push_a_timeout", 64'(g), 64'(0));
        @(posedge clk);
        @(negedge clk);
        in_valid_a = 1'b0; in_last_a = 1'b0;
    endtask

    task automatic push_b(input logic [OW-1:0] d);
        int g = 0;
        in_valid_b = 1'b1; in_data_b = d; in_last_b = 1'b0;
        while (!in_ready_b && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) check("push_b_timeout", 64'(g), 64'(0));
        @(posedge clk);
        @(negedge clk);
        in_valid_b = 1'b0;
    endtask

    task automatic pop_a(input string tag, input logic [OW-1:0] ed, input logic [CWA-1:0] en);
        int g = 0;
        while (!out_valid_a && g < 20) begin @(negedge clk); g++; end
        if (g >= 20) check({tag, "_valid_timeout"}, 64'(g), 64'(0));
        check({tag, "_data"}, 64'(out_data_a), 64'(ed));
        check({tag, "_n"}, 64'(out_n_a), 64'(en));
        out_ready_a = 1'b1;
        @(negedge clk);
        out_ready_a = 1'b0;
        check({tag, "_released"}, 64'(out_valid_a), 64'(0));
    endtask

    task automatic pop_b(input string tag, input logic [OW-1:0] ed);
        int g = 0;
        while (!out_valid_b && g < 20) begin @(negedge clk); g++; end
        if (g >= 20) check({tag, "_valid_timeout"}, 64'(g), 64'(0));
        check({tag, "_data"}, 64'(out_data_b), 64'(ed));
        check({tag, "_n"}, 64'(out_n_b), 64'(1));
`ifdef DTC_VOTE_COUNTS_EN
        check({tag, "_counts"}, 64'(out_counts_b), 64'(ed));
`endif
        out_ready_b = 1'b1;
        @(negedge clk);
        out_ready_b = 1'b0;
    endtask

    initial begin
        logic [OW*CWA-1:0] exp_counts;

        repeat (2) @(negedge clk);
        check("rst_in_ready_a", 64'(in_ready_a), 64'(0));
        check("rst_in_ready_b", 64'(in_ready_b), 64'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready_a), 64'(1));
        check("post_rst_out_valid", 64'(out_valid_a), 64'(0));
        check("post_rst_out_data", 64'(out_data_a), 64'(0));
        check("post_rst_out_n", 64'(out_n_a), 64'(0));
        @(negedge clk);

        // Full window of a constant pattern, with latency check.
        for (int i = 0; i < 8; i++) push_a(10'b1000000101, 1'b0);
        check("t1_eval_valid", 64'(out_valid_a), 64'(0));
        check("t1_eval_ready", 64'(in_ready_a), 64'(0));
        @(negedge clk);
        check("t1_hold_valid", 64'(out_valid_a), 64'(1));
`ifdef DTC_VOTE_COUNTS_EN
        exp_counts = '0;
        exp_counts[0*CWA +: CWA] = CWA'(8);
        exp_counts[2*CWA +: CWA] = CWA'(8);
        exp_counts[9*CWA +: CWA] = CWA'(8);
        check("t1_counts", 64'(out_counts_a), 64'(exp_counts));
`else
        exp_counts = '0;
`endif
        pop_a("t1", 10'b1000000101, CWA'(8));
        check("t1_back_in_acc", 64'(in_ready_a), 64'(1));

        // Exact tie resolves to 0.
        for (int i = 0; i < 4; i++) push_a(10'b1111111111, 1'b0);
        for (int i = 0; i < 4; i++) push_a(10'b0000000000, 1'b0);
        pop_a("t2_tie", 10'b0000000000, CWA'(8));

        // Early close on in_last.
        push_a(10'b0000000011, 1'b0);
        push_a(10'b0000000001, 1'b0);
        push_a(10'b0000000010, 1'b1);
        pop_a("t3_last", 10'b0000000011, CWA'(3));

        // in_last on the WIN-th sample is a normal close; 1 of 8 is no majority.
        for (int i = 0; i < 7; i++) push_a(10'b0000000000, 1'b0);
        push_a(10'b1111111111, 1'b1);
        pop_a("t3b_last_full", 10'b0000000000, CWA'(8));

        // Sink stall with upstream pushing: nothing consumed, result stable.
        for (int i = 0; i < 5; i++) push_a(10'b0011110000, 1'b0);
        for (int i = 0; i < 3; i++) push_a(10'b0000000000, 1'b0);
        @(negedge clk);
        in_valid_a = 1'b1; in_data_a = 10'b1111111111;
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_in_ready", 64'(in_ready_a), 64'(0));
            check("t4_stall_valid", 64'(out_valid_a), 64'(1));
            check("t4_stall_data", 64'(out_data_a), 64'(10'b0011110000));
            check("t4_stall_n", 64'(out_n_a), 64'(8));
            @(negedge clk);
        end
        in_valid_a = 1'b0;
        pop_a("t4", 10'b0011110000, CWA'(8));
        for (int i = 0; i < 8; i++) push_a(10'b0000000001, 1'b0);
        pop_a("t4_next", 10'b0000000001, CWA'(8));

        // Reset mid-window discards partial counts.
        for (int i = 0; i < 5; i++) push_a(10'b1111111111, 1'b0);
        rst = 1'b1;
        #1;
        check("t5_rst_in_ready", 64'(in_ready_a), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_rst_out_valid", 64'(out_valid_a), 64'(0));
        check("t5_rst_in_ready_after", 64'(in_ready_a), 64'(1));
        @(negedge clk);
        for (int i = 0; i < 8; i++) push_a(10'b0100000000, 1'b0);
        pop_a("t5", 10'b0100000000, CWA'(8));

        // WIN=1: output mirrors each sample.
        push_b(10'b1010101010); pop_b("w1_a", 10'b1010101010);
        push_b(10'b0101010101); pop_b("w1_b", 10'b0101010101);
        push_b(10'b1111111111); pop_b("w1_c", 10'b1111111111);
        push_b(10'b0000000000); pop_b("w1_d", 10'b0000000000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
